// File: rtl/systolic_seq_ctrl_if.sv
// systolic_seq_ctrl_if: operand-load, start/busy/done and array-feed bundle of the sequencer
interface systolic_seq_ctrl_if #(parameter int DW = 32);
  logic          ld_en;
  logic          ld_sel;
  logic [1:0]    ld_row;
  logic [1:0]    ld_col;
  logic [DW-1:0] ld_data;
  logic          ld_err;
  logic          start;
  logic          busy;
  logic          done;
  logic          arr_clr;
  logic [DW-1:0] west0, west1, west2, west3;
  logic [DW-1:0] north0, north1, north2, north3;
  modport master (
    output ld_en, ld_sel, ld_row, ld_col, ld_data, start,
    input  ld_err, busy, done, arr_clr,
    input  west0, west1, west2, west3, north0, north1, north2, north3
  );
  modport slave (
    input  ld_en, ld_sel, ld_row, ld_col, ld_data, start,
    output ld_err, busy, done, arr_clr,
    output west0, west1, west2, west3, north0, north1, north2, north3
  );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: holds A/B operand banks and streams them diagonally skewed into a 4x4 systolic array
module systolic_seq_ctrl #(
  parameter int N            = 4,
  parameter int DW           = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input logic                clk,
  input logic                rst,
  systolic_seq_ctrl_if.slave io
);
  localparam int CW = $clog2(DRAIN_CYCLES + 2 * N);
  localparam int IW = $clog2(N);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
  state_t        state, nstate;
  logic [CW-1:0] cnt, ncnt;
  logic [DW-1:0] a [N][N];
  logic [DW-1:0] b [N][N];
  logic [DW-1:0] west_d [N];
  logic [DW-1:0] north_d [N];
  logic [DW-1:0] west_q [N];
  logic [DW-1:0] north_q [N];
  logic          ld_ok;
  logic          ld_err_q;
  assign ld_ok      = io.ld_en && (state == IDLE || state == DONE);
  assign io.busy    = state == CLEAR || state == FEED || state == DRAIN;
  assign io.done    = state == DONE;
  assign io.arr_clr = state == CLEAR;
  assign io.ld_err  = ld_err_q;
  assign io.west0   = west_q[0];
  assign io.west1   = west_q[1];
  assign io.west2   = west_q[2];
  assign io.west3   = west_q[3];
  assign io.north0  = north_q[0];
  assign io.north1  = north_q[1];
  assign io.north2  = north_q[2];
  assign io.north3  = north_q[3];
  // state register and shared FEED step / DRAIN counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
    end
  end
  // sequencing: one clear cycle, 2N-1 feed steps, fixed drain, one done cycle
  always_comb begin
    nstate = state;
    ncnt   = '0;
    case (state)
      IDLE:  nstate = io.start ? CLEAR : IDLE;
      CLEAR: nstate = FEED;
      FEED: begin
        nstate = (cnt == CW'(2 * N - 2)) ? DRAIN : FEED;
        ncnt   = (cnt == CW'(2 * N - 2)) ? '0 : cnt + CW'(1);
      end
      DRAIN: begin
        nstate = (cnt == CW'(DRAIN_CYCLES - 1)) ? DONE : DRAIN;
        ncnt   = (cnt == CW'(DRAIN_CYCLES - 1)) ? '0 : cnt + CW'(1);
      end
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end
  // skew selection for the upcoming cycle: row/column i lags by i steps, zero outside its window
  always_comb begin
    for (int i = 0; i < N; i++) begin
      west_d[i]  = '0;
      north_d[i] = '0;
      if (nstate == FEED && ncnt >= CW'(i) && ncnt - CW'(i) < CW'(N)) begin
        west_d[i]  = a[i][IW'(ncnt - CW'(i))];
        north_d[i] = b[IW'(ncnt - CW'(i))][i];
      end
    end
  end
  // registered edge outputs so the array sees clean, glitch-free operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      west_q  <= '{default: '0};
      north_q <= '{default: '0};
    end else begin
      west_q  <= west_d;
      north_q <= north_d;
    end
  end
  // operand banks are writable only while no run is in flight; rejected writes flag ld_err
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a        <= '{default: '0};
      b        <= '{default: '0};
      ld_err_q <= 1'b0;
    end else begin
      ld_err_q <= io.ld_en && !ld_ok;
      if (ld_ok && !io.ld_sel) a[io.ld_row][io.ld_col] <= io.ld_data;
      if (ld_ok && io.ld_sel) b[io.ld_row][io.ld_col] <= io.ld_data;
    end
  end
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: scoreboard bench with a behavioural matrix/array reference for systolic_seq_ctrl
module tb_systolic_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  systolic_seq_ctrl_if #(.DW(32)) bus ();
  systolic_seq_ctrl #(.N(4), .DW(32), .DRAIN_CYCLES(4)) dut (.clk(clk), .rst(rst), .io(bus));
  typedef struct packed {
    int                    acc;
    logic [6:0][255:0]     feed;
    logic [15:0][31:0]     prod;
  } exp_t;
  exp_t        q[$];
  int          total = 0;
  int          passed = 0;
  int          cyc = 0;
  int          runs = 0;
  int          dones = 0;
  logic [31:0] ma [4][4];
  logic [31:0] mb [4][4];
  logic [31:0] pa [4][4];
  logic [31:0] pb [4][4];
  logic [31:0] acc [4][4];
  logic [31:0] w [4];
  logic [31:0] n [4];
  assign w[0] = bus.west0;
  assign w[1] = bus.west1;
  assign w[2] = bus.west2;
  assign w[3] = bus.west3;
  assign n[0] = bus.north0;
  assign n[1] = bus.north1;
  assign n[2] = bus.north2;
  assign n[3] = bus.north3;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [255:0] feed_now();
    return {bus.west0, bus.west1, bus.west2, bus.west3, bus.north0, bus.north1, bus.north2, bus.north3};
  endfunction
  function automatic logic [31:0] ain(int i, int j);
    return j == 0 ? w[i] : pa[i][j == 0 ? 0 : j - 1];
  endfunction
  function automatic logic [31:0] bin(int i, int j);
    return i == 0 ? n[j] : pb[i == 0 ? 0 : i - 1][j];
  endfunction
  // downstream 4x4 output-stationary array driven by the DUT's edge outputs
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (rst || bus.arr_clr) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= '0;
        end else begin
          pa[i][j]  <= ain(i, j);
          pb[i][j]  <= bin(i, j);
          acc[i][j] <= acc[i][j] + ain(i, j) * bin(i, j);
        end
  end
  task automatic check(input string nm, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_exp();
    exp_t        e;
    logic [31:0] s;
    e     = '0;
    e.acc = cyc;
    for (int t = 0; t < 7; t++)
      for (int i = 0; i < 4; i++)
        if (t >= i && t - i < 4) begin
          e.feed[t][255-32*i -: 32] = ma[i][t-i];
          e.feed[t][127-32*i -: 32] = mb[t-i][i];
        end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = '0;
        for (int k = 0; k < 4; k++) s += ma[i][k] * mb[k][j];
        e.prod[i*4+j] = s;
      end
    q.push_back(e);
    runs++;
  endtask
  task automatic load(input bit sel, input int r, input int c, input logic [31:0] d, input bit rej);
    bus.ld_en   = 1'b1;
    bus.ld_sel  = sel;
    bus.ld_row  = 2'(r);
    bus.ld_col  = 2'(c);
    bus.ld_data = d;
    tick();
    bus.ld_en = 1'b0;
    check("ld_err", bus.ld_err, rej);
    if (!rej) begin
      if (sel) mb[r][c] = d;
      else ma[r][c] = d;
    end else begin
      tick();
      check("ld_err_pulse", bus.ld_err, 0);
    end
  endtask
  task automatic load_all(input int kind);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        load(0, r, c, kind == 0 ? 32'(r == c) : kind == 1 ? 32'(16 * r + c) : $urandom, 0);
        load(1, r, c, kind == 0 ? 32'(4 * r + c + 1) : kind == 1 ? 32'd0 : $urandom, 0);
      end
  endtask
  task automatic go(input bit wl = 0, input logic [31:0] d = 0);
    bus.start = 1'b1;
    if (wl) begin
      bus.ld_en   = 1'b1;
      bus.ld_sel  = 1'b0;
      bus.ld_row  = 2'd0;
      bus.ld_col  = 2'd0;
      bus.ld_data = d;
    end
    tick();
    bus.start = 1'b0;
    bus.ld_en = 1'b0;
    if (wl) ma[0][0] = d;
    push_exp();
  endtask
  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = bus.done;
    end
    check("done_seen", seen, 1);
    tick();
  endtask
  // monitor: pops one expected run per arr_clr and checks every following cycle through done
  initial begin : mon
    exp_t cur;
    int   step;
    bit   active;
    active = 1'b0;
    step   = 0;
    cur    = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.done) dones++;
      if (rst) active = 1'b0;
      else if (active) begin
        check("run_outputs", {bus.busy, bus.done, bus.arr_clr, feed_now()},
              {step < 11, step == 11, 1'b0, step < 7 ? cur.feed[step] : 256'b0});
        if (step == 11) begin
          for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) check("product", acc[i][j], cur.prod[i*4+j]);
          active = 1'b0;
        end else step++;
      end else if (bus.arr_clr) begin
        check("queued_run", q.size() != 0, 1);
        if (q.size() != 0) begin
          cur = q.pop_front();
          check("accept_cycle", cyc, cur.acc);
          check("clear_outputs", {bus.busy, bus.done, feed_now()}, {1'b1, 1'b0, 256'b0});
          active = 1'b1;
          step   = 0;
        end
      end else check("idle_outputs", {bus.busy, bus.done, feed_now()}, '0);
    end
  end
  initial begin
    bus.ld_en   = 1'b0;
    bus.ld_sel  = 1'b0;
    bus.ld_row  = 2'd0;
    bus.ld_col  = 2'd0;
    bus.ld_data = '0;
    bus.start   = 1'b0;
    ma = '{default: '0};
    mb = '{default: '0};
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {bus.busy, bus.done, bus.arr_clr, bus.ld_err, feed_now()}, '0);
    rst = 1'b0;
    load_all(0);
    go();
    wait_done();
    load_all(1);
    go();
    wait_done();
    go();
    tick();
    tick();
    load(0, 1, 1, 32'hdead, 1);
    wait_done();
    load(0, 2, 1, 32'h55, 0);
    go();
    wait_done();
    go();
    repeat (8) tick();
    bus.start = 1'b1;
    tick();
    tick();
    bus.start = 1'b0;
    check("busy_drain", bus.busy, 1);
    wait_done();
    bus.start = 1'b1;
    tick();
    push_exp();
    repeat (2) begin
      repeat (14) tick();
      push_exp();
    end
    bus.start = 1'b0;
    wait_done();
    go();
    repeat (5) tick();
    #1 rst = 1'b1;
    #1 check("async_reset", {bus.busy, bus.done, bus.arr_clr, feed_now()}, '0);
    runs--;
    tick();
    tick();
    rst = 1'b0;
    ma = '{default: '0};
    mb = '{default: '0};
    go();
    wait_done();
    load_all(2);
    go();
    wait_done();
    go(1, 32'd7);
    wait_done();
    repeat (2) begin
      load_all(2);
      go();
      wait_done();
    end
    tick();
    check("done_count", dones, runs);
    check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
Sequencer for the 4x4 output-stationary systolic array. It holds operand matrix A (rows feed the west edge) and matrix B (columns feed the north edge) in internal register banks. On start it clears the array, then streams both matrices with diagonal skew onto the array's four west and four north inputs. It waits for the wavefront to drain and pulses done, replacing the array's free-running count-to-9 timer with a start/busy/done handshake.

Parameters:
N, 4, array dimension; only 4 is supported.
DW, 32, operand width.
DRAIN_CYCLES, 4, cycles held in DRAIN after the last feed step; must be >= 1.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
ld_en  in  1  write one operand word into a bank
ld_sel  in  1  0 = bank A, 1 = bank B
ld_row  in  2  row index
ld_col  in  2  column index
ld_data  in  DW  operand word
ld_err  out  1  one-cycle pulse when ld_en is rejected
start  in  1  begin a matrix multiply
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle completion pulse
arr_clr  out  1  clear to the array; drives the array's rst input
west0..west3  out  DW each  west-edge inputs to array rows 0..3
north0..north3  out  DW each  north-edge inputs to array columns 0..3

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; counters reset to 0.
  - Both banks clear to 0.
  - busy=0, done=0, ld_err=0, arr_clr=0, all west/north outputs=0.
  - Reset mid-operation aborts immediately with the same values; no done pulse follows.
- State machine:
  - IDLE --start--> CLEAR (1 cycle) --> FEED (2N-1 = 7 cycles) --> DRAIN (DRAIN_CYCLES cycles) --> DONE (1 cycle) --> IDLE.
- Outputs per state:
  - busy=1 in CLEAR, FEED and DRAIN.
  - done=1 only in DONE; busy=0 in DONE.
  - arr_clr=1 only in CLEAR.
- start:
  - Sampled only in IDLE.
  - Ignored in every other state, including DONE; no queuing.
  - Level or pulse both accepted; if start is held, a new run begins on the cycle after DONE.
- Loads:
  - Accepted only when state is IDLE or DONE. The bank write happens at the clock edge.
  - ld_en in any other state is dropped, the bank is unchanged, and ld_err pulses high on the next cycle.
  - A load accepted in the same cycle as an accepted start is written, and the new value is used by that run.
- Feed timing:
  - Step counter t runs 0..6 during FEED.
  - All west/north outputs are registered. During the FEED cycle with counter t:
    - west_i = A[i][t-i] if 0 <= t-i <= 3, else 0.
    - north_j = B[t-j][j] if 0 <= t-j <= 3, else 0.
  - Outputs are 0 in every non-FEED cycle, so the array sees zeros while draining.
- Latency: start accepted at edge k gives done high in cycle k + 1 + 7 + DRAIN_CYCLES + 1 (13 cycles after acceptance with defaults).
- Banks are not modified by a run, so back-to-back runs reuse the operands.
- No arithmetic is performed here. Products and accumulation stay in the array's processing elements.

Test Plan:
- Load A = identity and B[r][c] = 4r+c+1; pulse start -> arr_clr high for exactly 1 cycle; first FEED cycle has west0=1, north0=1, all others 0; done pulses 13 cycles after start acceptance; array results equal B.
- Skew check: A[i][k] = 16*i+k, B = 0, step counter t=3 -> west0=3, west1=18, west2=33, west3=48. At t=6 -> west3=51 and west0..2=0.
- ld_en during FEED -> target bank word unchanged, ld_err pulses 1 cycle; ld_en in IDLE -> ld_err stays 0 and the word reads back via the next run's feed values.
- start reasserted during DRAIN -> ignored; busy stays 1; exactly one done pulse. start held high continuously -> runs repeat with a 14-cycle period, done once per run.
- Assert rst at FEED t=4 -> outputs zero and busy=0 asynchronously; no done pulse; a subsequent run with freshly loaded banks completes normally.
- Load accepted in the same cycle as start, writing A[0][0]=7 -> the run's first FEED cycle drives west0=7.
